// File: rtl/axi_rd_burst_master_if.sv
// AXI4 read-address and read-data channels shared by the burst master.
// The master modport drives AR* and RREADY; the slave modport drives the rest.
interface axi_rd_burst_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [3:0]              ARREGION;
  logic [LEN_WIDTH-1:0]    ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARLOCK;
  logic [3:0]              ARCACHE;
  logic [2:0]              ARPROT;
  logic [3:0]              ARQOS;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [USER_WIDTH-1:0]   ARUSER;
  logic [ID_WIDTH-1:0]     RID;
  logic [STRB_WIDTH*8-1:0] RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;
  logic [USER_WIDTH-1:0]   RUSER;

  modport master (
    output ARID, ARADDR, ARREGION, ARLEN, ARSIZE,
    output ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS,
    output ARVALID, ARUSER, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST,
    input  RVALID, RUSER
  );

  modport slave (
    input  ARID, ARADDR, ARREGION, ARLEN, ARSIZE,
    input  ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS,
    input  ARVALID, ARUSER, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST,
    output RVALID, RUSER
  );
endinterface

// File: rtl/axi_rd_burst_master.sv
// AXI4 read burst master: splits a command into INCR bursts that
// never cross a 4 KB page, one burst outstanding, data passed through.
module axi_rd_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 1,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CNT_WIDTH-1:0]    cmd_beats,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [STRB_WIDTH*8-1:0] dout_data,
  output logic                    dout_last,
  output logic                    done,
  output logic                    err,
  input  logic                    err_clr,
  axi_rd_burst_master_if.master   m_axi
);

  localparam int SZ = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]  r_blen;
  logic [CNT_WIDTH-1:0]  r_bcnt;
  logic [CNT_WIDTH-1:0]  r_rem;
  logic                  r_arvalid;
  logic                  r_cmd_ready;
  logic                  r_done;
  logic                  r_err;

  logic                  w_cmd_fire;
  logic                  w_in_data;
  logic                  w_beat;
  logic                  w_last_exp;
  logic                  w_new_err;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [CNT_WIDTH-1:0]  w_next_blen;
  logic [CNT_WIDTH-1:0]  w_cmd_blen;
  logic                  w_unused;

  // Beats in the next burst: limited by what is left, the burst cap
  // and the distance to the end of the current 4 KB page.
  function automatic logic [CNT_WIDTH-1:0] f_blen(
    input logic [11:0]          a,
    input logic [CNT_WIDTH-1:0] rem
  );
    logic [31:0] v_4k;
    logic [31:0] v_b;
    v_4k = (32'd4096 - {20'd0, a}) >> SZ;
    v_b  = 32'(rem);
    if (v_b > 32'(MAX_BURST)) v_b = 32'(MAX_BURST);
    if (v_b > v_4k) v_b = v_4k;
    return CNT_WIDTH'(v_b);
  endfunction

  assign w_cmd_fire  = cmd_valid & r_cmd_ready;
  assign w_in_data   = (r_state == DATA);
  assign w_beat      = w_in_data & m_axi.RVALID & dout_ready;
  assign w_last_exp  = (r_bcnt == r_blen - CNT_WIDTH'(1));
  assign w_next_addr = r_addr + (ADDR_WIDTH'(r_blen) << SZ);
  assign w_next_blen = f_blen(w_next_addr[11:0], r_rem);
  assign w_cmd_blen  = f_blen(cmd_addr[11:0], cmd_beats);
  assign w_new_err   = w_beat &
                       ((m_axi.RRESP != 2'b00) |
                        (m_axi.RLAST != w_last_exp));

  assign cmd_ready  = r_cmd_ready;
  assign done       = r_done;
  assign err        = r_err;
  assign dout_valid = w_in_data & m_axi.RVALID;
  assign dout_data  = m_axi.RDATA;
  assign dout_last  = dout_valid & w_last_exp &
                      (r_rem == '0);

  assign m_axi.ARID     = '0;
  assign m_axi.ARADDR   = r_addr;
  assign m_axi.ARREGION = 4'd0;
  assign m_axi.ARLEN    = LEN_WIDTH'(r_blen - CNT_WIDTH'(1));
  assign m_axi.ARSIZE   = 3'(SZ);
  assign m_axi.ARBURST  = 2'b01;
  assign m_axi.ARLOCK   = 1'b0;
  assign m_axi.ARCACHE  = 4'b0011;
  assign m_axi.ARPROT   = 3'd0;
  assign m_axi.ARQOS    = 4'd0;
  assign m_axi.ARUSER   = '0;
  assign m_axi.ARVALID  = r_arvalid;
  assign m_axi.RREADY   = w_in_data & dout_ready;

  assign w_unused = ^{m_axi.RID, m_axi.RUSER};

  // Command sequencer: address phase, data phase, burst rollover, done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_blen      <= '0;
      r_bcnt      <= '0;
      r_rem       <= '0;
      r_arvalid   <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= (r_err & ~err_clr) | w_new_err;
      unique case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_cmd_ready <= 1'b0;
            if (cmd_beats == '0) begin
              r_state <= DONE;
            end else begin
              r_addr    <= cmd_addr;
              r_blen    <= w_cmd_blen;
              r_rem     <= cmd_beats - w_cmd_blen;
              r_arvalid <= 1'b1;
              r_state   <= ADDR;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ADDR: begin
          if (m_axi.ARREADY) begin
            r_arvalid <= 1'b0;
            r_bcnt    <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_beat) begin
            if (w_last_exp) begin
              if (r_rem == '0) begin
                r_state <= DONE;
              end else begin
                r_addr    <= w_next_addr;
                r_blen    <= w_next_blen;
                r_rem     <= r_rem - w_next_blen;
                r_arvalid <= 1'b1;
                r_state   <= ADDR;
              end
            end else begin
              r_bcnt <= r_bcnt + CNT_WIDTH'(1);
            end
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Bench for axi_rd_burst_master: AXI slave model, directed table,
// error and reset sequences, random commands with stalls.
module tb_axi_rd_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        dout_valid;
  logic        dout_ready;
  logic [63:0] dout_data;
  logic        dout_last;
  logic        done;
  logic        err;
  logic        err_clr;

  axi_rd_burst_master_if m ();

  axi_rd_burst_master dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_beats  (cmd_beats),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_last  (dout_last),
    .done       (done),
    .err        (err),
    .err_clr    (err_clr),
    .m_axi      (m)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      addr;
    logic [15:0]      beats;
    logic [1:0]       nar;
    logic [2:0][31:0] a;
    logic [2:0][7:0]  l;
  } vec_t;

  vec_t        tbl [6];
  int          total = 0;
  int          bad = 0;

  logic [31:0] obs_a [$];
  int          obs_l [$];
  logic [63:0] obs_d [$];
  bit          obs_last [$];
  int          done_cnt = 0;

  logic [31:0] sq_a [$];
  int          sq_l [$];
  int          sidx = 0;
  int          gbeat = 0;
  int          inj_resp = -1;
  int          inj_last = -1;
  bit          stall = 1'b0;

  bit          ar_fire;
  bit          r_fire;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_a;
  logic [7:0]  prev_l;
  logic [22:0] fx;

  function automatic logic [63:0] pat(input logic [31:0] x);
    return {x, x ^ 32'hA5A5_5A5A};
  endfunction

  task automatic chk(input string nm, input bit ok,
                     input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Slave model and monitor: observe at negedge, drive after posedge.
  initial begin
    m.ARREADY = 1'b1;
    m.RID     = '0;
    m.RDATA   = '0;
    m.RRESP   = 2'b00;
    m.RLAST   = 1'b0;
    m.RVALID  = 1'b0;
    m.RUSER   = '0;
    dout_ready = 1'b1;
    forever begin
      @(negedge clk);
      ar_fire = m.ARVALID && m.ARREADY;
      r_fire  = m.RVALID && m.RREADY;
      if (rst) begin
        if (prev_pend)
          chk("ar stable",
              m.ARVALID && m.ARADDR == prev_a && m.ARLEN == prev_l,
              longint'(m.ARADDR), longint'(prev_a));
        if (ar_fire) begin
          fx = {m.ARID, m.ARSIZE, m.ARBURST, m.ARLOCK, m.ARCACHE,
                m.ARPROT, m.ARQOS, m.ARREGION, m.ARUSER};
          chk("ar fixed", fx == 23'b0_011_01_0_0011_000_0000_0000_0,
              longint'(fx), longint'(23'b0_011_01_0_0011_000_0000_0000_0));
          obs_a.push_back(m.ARADDR);
          obs_l.push_back(int'(m.ARLEN));
          sq_a.push_back(m.ARADDR);
          sq_l.push_back(int'(m.ARLEN));
        end
        if (dout_valid && dout_ready) begin
          obs_d.push_back(dout_data);
          obs_last.push_back(dout_last);
        end
        if (done) done_cnt++;
      end
      prev_pend = rst && m.ARVALID && !m.ARREADY;
      prev_a    = m.ARADDR;
      prev_l    = m.ARLEN;
      @(posedge clk);
      #1;
      if (!rst) begin
        sq_a.delete();
        sq_l.delete();
        sidx  = 0;
        gbeat = 0;
      end else if (r_fire && sq_a.size() > 0) begin
        gbeat++;
        if (sidx == sq_l[0]) begin
          void'(sq_a.pop_front());
          void'(sq_l.pop_front());
          sidx = 0;
        end else begin
          sidx++;
        end
      end
      m.ARREADY  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      dout_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sq_a.size() > 0) begin
        if (!(m.RVALID && !r_fire))
          m.RVALID = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        m.RDATA = pat(sq_a[0] + 32'(sidx * 8));
        m.RRESP = (gbeat == inj_resp) ? 2'b10 : 2'b00;
        m.RLAST = (inj_last >= 0) ? (gbeat == inj_last)
                                  : (sidx == sq_l[0]);
      end else begin
        m.RVALID = 1'b0;
        m.RLAST  = 1'b0;
      end
    end
  end

  task automatic run_cmd(input logic [31:0] a, input int n);
    int t;
    @(negedge clk);
    #2;
    obs_a.delete();
    obs_l.delete();
    obs_d.delete();
    obs_last.delete();
    done_cnt = 0;
    gbeat    = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_beats = 16'(n);
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cmd accept", t < 100, t, 100);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("cmd done timeout", t < 5000, t, 5000);
    repeat (3) @(negedge clk);
  endtask

  // Reference: page-aware burst split and linear beat stream.
  task automatic check_cmd(input logic [31:0] a, input int n,
                           input string tag);
    logic [31:0] ea [$];
    int          el [$];
    logic [31:0] x;
    int          rem;
    int          b;
    int          pg;
    bit          ok;
    x   = a;
    rem = n;
    while (rem > 0) begin
      pg = (4096 - int'(x % 32'd4096)) / 8;
      b  = rem;
      if (b > 16) b = 16;
      if (b > pg) b = pg;
      ea.push_back(x);
      el.push_back(b - 1);
      x   = x + 32'(b * 8);
      rem = rem - b;
    end
    ok = (obs_a.size() == ea.size());
    for (int i = 0; i < ea.size() && ok; i++)
      if (obs_a[i] != ea[i] || obs_l[i] != el[i]) ok = 1'b0;
    chk({tag, " ar list"}, ok, obs_a.size(), ea.size());
    ok = (obs_d.size() == n);
    for (int k = 0; k < n && ok; k++)
      if (obs_d[k] != pat(a + 32'(k * 8)) ||
          obs_last[k] != (k == n - 1)) ok = 1'b0;
    chk({tag, " beats"}, ok, obs_d.size(), n);
    chk({tag, " done cnt"}, done_cnt == 1, done_cnt, 1);
  endtask

  initial begin
    logic [31:0] a;
    int          n;
    int          t;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_beats = '0;
    err_clr   = 1'b0;

    tbl[0] = '{addr: 32'h1000, beats: 16'd40, nar: 2'd3,
               a: {32'h1100, 32'h1080, 32'h1000},
               l: {8'd7, 8'd15, 8'd15}};
    tbl[1] = '{addr: 32'h0FE0, beats: 16'd10, nar: 2'd2,
               a: {32'h0, 32'h1000, 32'h0FE0},
               l: {8'd0, 8'd5, 8'd3}};
    tbl[2] = '{addr: 32'h0, beats: 16'd0, nar: 2'd0,
               a: '0, l: '0};
    tbl[3] = '{addr: 32'h2FF8, beats: 16'd3, nar: 2'd2,
               a: {32'h0, 32'h3000, 32'h2FF8},
               l: {8'd0, 8'd1, 8'd0}};
    tbl[4] = '{addr: 32'h0040, beats: 16'd16, nar: 2'd1,
               a: {32'h0, 32'h0, 32'h0040},
               l: {8'd0, 8'd0, 8'd15}};
    tbl[5] = '{addr: 32'h0FF8, beats: 16'd20, nar: 2'd3,
               a: {32'h1080, 32'h1000, 32'h0FF8},
               l: {8'd2, 8'd15, 8'd0}};

    #3;
    chk("reset outs",
        {m.ARVALID, m.RREADY, dout_valid, dout_last,
         done, err, cmd_ready} == 7'd0,
        {m.ARVALID, m.RREADY, dout_valid, dout_last,
         done, err, cmd_ready}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("cmd_ready before edge", cmd_ready == 1'b0, cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready after rst", cmd_ready == 1'b1, cmd_ready, 1);

    obs_a.delete();
    done_cnt = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0;
    cmd_beats = 16'd0;
    @(negedge clk);
    chk("zero hs", cmd_ready == 1'b1, cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("zero c1", {done, cmd_ready} == 2'b00, {done, cmd_ready}, 0);
    @(negedge clk);
    chk("zero c2", {done, cmd_ready} == 2'b10, {done, cmd_ready}, 2);
    @(negedge clk);
    chk("zero c3", {done, cmd_ready} == 2'b01, {done, cmd_ready}, 1);
    chk("zero no ar", obs_a.size() == 0, obs_a.size(), 0);

    for (int i = 0; i < 6; i++) begin
      run_cmd(tbl[i].addr, int'(tbl[i].beats));
      chk("tbl nar", obs_a.size() == int'(tbl[i].nar),
          obs_a.size(), tbl[i].nar);
      for (int j = 0; j < int'(tbl[i].nar); j++) begin
        chk("tbl araddr", obs_a[j] == tbl[i].a[j],
            obs_a[j], tbl[i].a[j]);
        chk("tbl arlen", obs_l[j] == int'(tbl[i].l[j]),
            obs_l[j], tbl[i].l[j]);
      end
      check_cmd(tbl[i].addr, int'(tbl[i].beats), "tbl");
    end
    chk("tbl err", err == 1'b0, err, 0);

    inj_resp = 2;
    inj_last = 4;
    run_cmd(32'h0, 16);
    check_cmd(32'h0, 16, "err cmd");
    chk("err set", err == 1'b1, err, 1);
    inj_resp = -1;
    inj_last = -1;
    run_cmd(32'h200, 5);
    check_cmd(32'h200, 5, "err after");
    chk("err sticky", err == 1'b1, err, 1);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("err clr", err == 1'b0, err, 0);

    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 32'($urandom_range(0, 3)) * 32'd4096;
      if ($urandom_range(0, 1) != 0)
        a = a + 32'd4096 - 32'($urandom_range(1, 24)) * 32'd8;
      else
        a = a + 32'($urandom_range(0, 500)) * 32'd8;
      n = $urandom_range(0, 50);
      run_cmd(a, n);
      check_cmd(a, n, "rand");
    end
    stall = 1'b0;
    chk("rand err", err == 1'b0, err, 0);

    @(negedge clk);
    #2;
    obs_d.delete();
    obs_last.delete();
    gbeat    = 0;
    inj_resp = 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0;
    cmd_beats = 16'd64;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    t = 0;
    while (obs_d.size() < 6 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid beats", t < 200, t, 200);
    chk("pre rst err", err == 1'b1, err, 1);
    chk("pre rst valid", dout_valid == 1'b1, dout_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid rst outs",
        {m.ARVALID, m.RREADY, dout_valid, dout_last,
         done, err, cmd_ready} == 7'd0,
        {m.ARVALID, m.RREADY, dout_valid, dout_last,
         done, err, cmd_ready}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    inj_resp = -1;
    @(negedge clk);
    chk("post rst low", cmd_ready == 1'b0, cmd_ready, 0);
    @(negedge clk);
    chk("post rst rdy", cmd_ready == 1'b1, cmd_ready, 1);
    run_cmd(32'h3000, 20);
    check_cmd(32'h3000, 20, "post rst");
    chk("post rst err", err == 1'b0, err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_burst_master.md
AXI_RD_BURST_MASTER -- requirements
Module: axi_rd_burst_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width in bits.
REQ-002 The block SHALL have parameter STRB_WIDTH, default 8, meaning data bus width in bytes (power of two, 1..128).
REQ-003 The block SHALL have parameter LEN_WIDTH, default 8, meaning ARLEN width (AXI4).
REQ-004 The block SHALL have parameter ID_WIDTH, default 1, meaning ARID/RID width.
REQ-005 The block SHALL have parameter MAX_BURST, default 16, meaning maximum beats per burst (1..2^LEN_WIDTH).
REQ-006 The block SHALL have parameter CNT_WIDTH, default 16, meaning command beat-count width.
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-008 Ports, one per line: name  direction  width  meaning.
 clk  in  1  clock, rising edge
 rst  in  1  asynchronous active-low reset
 cmd_valid  in  1  command request
 cmd_ready  out  1  command accepted when high with cmd_valid
 cmd_addr  in  ADDR_WIDTH  start byte address, STRB_WIDTH-aligned
 cmd_beats  in  CNT_WIDTH  total beats to read
 dout_valid  out  1  read data valid
 dout_ready  in  1  downstream ready
 dout_data  out  STRB_WIDTH*8  read data
 dout_last  out  1  final beat of the command
 done  out  1  one-cycle pulse, command complete
 err  out  1  sticky error flag
 err_clr  in  1  clears err
 AR* (ARID, ARADDR, ARREGION, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID, ARUSER)  out, ARREADY  in  AXI4 widths
 RID, RDATA, RRESP, RLAST, RVALID, RUSER  in, RREADY  out  AXI4 widths

Function
REQ-009 FSM states SHALL be IDLE, ADDR, DATA, DONE; cmd_ready=1 only in IDLE.
REQ-010 IDLE: cmd_valid&cmd_ready SHALL latch addr/beats; beats=0 -> DONE, else -> ADDR.
REQ-011 Burst length SHALL be min(remaining beats, MAX_BURST, beats to next 4 KB boundary = (4096 - addr[11:0]) / STRB_WIDTH).
REQ-012 ADDR: ARVALID=1, ARADDR=current addr, ARLEN=burst-1, all AR fields stable until ARVALID&ARREADY, then -> DATA.
REQ-013 Fixed AR fields SHALL be ARID=0, ARSIZE=log2(STRB_WIDTH), ARBURST=2'b01, ARLOCK=0, ARCACHE=4'b0011, ARPROT=0, ARQOS=0, ARREGION=0, ARUSER=0.
REQ-014 Exactly one burst SHALL be outstanding; the next AR issues only after the current burst's final beat.
REQ-015 DATA: dout_valid=RVALID, RREADY=dout_ready, dout_data=RDATA (combinational pass-through); a beat transfers on RVALID&RREADY.
REQ-016 Internal beat counter SHALL decide burst end; RLAST at a different beat than expected SHALL set err without altering the sequence.
REQ-017 RRESP!=2'b00 on any transferred beat SHALL set err; data still forwarded.
REQ-018 After burst end: remaining>0 -> addr += burst*STRB_WIDTH, -> ADDR; remaining=0 -> DONE.
REQ-019 dout_last SHALL be 1 only on the final beat of the whole command.
REQ-020 DONE: done=1 for one cycle, -> IDLE.
REQ-021 err SHALL hold until err_clr=1; err_clr and a new error same cycle -> err stays 1.
REQ-022 Outside DATA, RREADY=0 and dout_valid=0; outside ADDR, ARVALID=0.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, ARVALID=0, RREADY=0, dout_valid=0, dout_last=0, done=0, err=0, cmd_ready=0 during reset, counters=0.
REQ-024 Reset mid-burst SHALL abandon the transaction; no recovery of in-flight beats is required.
REQ-025 cmd_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-026 addr=0x1000, beats=40, MAX_BURST=16, ARREADY=1 -> ARLEN 15,15,7 at 0x1000,0x1080,0x1100; 40 beats; dout_last on beat 40; one done pulse.
REQ-027 addr=0x0FE0, beats=10, STRB_WIDTH=8 -> ARLEN 3 at 0x0FE0, ARLEN 5 at 0x1000; no 4 KB crossing.
REQ-028 beats=0 -> no ARVALID, done pulse two cycles after handshake, cmd_ready back next cycle.
REQ-029 RRESP=2'b10 on beat 3, RLAST early on beat 5 of 16 -> err=1, all 16 beats forwarded, err cleared only by err_clr.
REQ-030 Random dout_ready/ARREADY stalls -> AR fields stable while ARVALID high, no beat lost/duplicated; rst=0 mid-DATA -> all outputs at reset values same cycle.
